// File: rtl/clk_ratio_meas.sv
// clk_ratio_meas: measures the period of a slow, asynchronous clock-like input
// in i_ref_clk cycles and reports it as a divide ratio. It also raises a
// stable flag after a run of identical periods and pulses a timeout when the
// input stops toggling long enough for the period counter to saturate.
module clk_ratio_meas #(
    parameter int RATIO_WD   = 8,
    parameter int STABLE_CNT = 4
) (
    input  logic                i_ref_clk,
    input  logic                i_rst,
    input  logic                i_meas_en,
    input  logic                i_clk_in,
    output logic [RATIO_WD-1:0] o_ratio,
    output logic                o_ratio_vld,
    output logic                o_stable,
    output logic                o_timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_ARM   = 2'd2;
    localparam logic [1:0] ST_COUNT = 2'd3;

    localparam logic [RATIO_WD-1:0] CNT_MAX  = {RATIO_WD{1'b1}};
    localparam logic [RATIO_WD-1:0] CNT_ZERO = '0;
    localparam logic [RATIO_WD-1:0] CNT_ONE  = RATIO_WD'(1);
    localparam logic [3:0]          STABLE_TGT = 4'(STABLE_CNT);

    // Input synchronizer and edge detector
    logic sync1;
    logic sync2;
    logic d3;
    logic rise;
    // The synchronizer holds its reset zeros for two edges after reset, so
    // sync2 says nothing about the real input level until then. Without this
    // a high input at reset release looks low and then rises: a false edge.
    logic [1:0] primed;

    // Control
    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [RATIO_WD-1:0] cnt;
    logic [RATIO_WD-1:0] cnt_nxt;
    logic [3:0]          match_cnt;
    logic [3:0]          match_nxt;
    logic                prev_vld;

    // Events decoded from the current state
    logic meas_evt;
    logic tmo_evt;
    logic arm_evt;

    // Saturating increment of the match counter; stops at the stable target.
    function automatic logic [3:0] match_sat_inc(input logic [3:0] m);
        if (m >= STABLE_TGT) begin
            return STABLE_TGT;
        end
        return m + 4'd1;
    endfunction

    // Saturating increment of the period counter; never wraps past CNT_MAX.
    function automatic logic [RATIO_WD-1:0] cnt_sat_inc(input logic [RATIO_WD-1:0] c);
        if (c == CNT_MAX) begin
            return CNT_MAX;
        end
        return c + CNT_ONE;
    endfunction

    assign rise = sync2 & ~d3;

    assign meas_evt = i_meas_en && (state == ST_COUNT) && rise;
    assign tmo_evt  = i_meas_en && (state == ST_COUNT) && !rise && (cnt == CNT_MAX);
    assign arm_evt  = i_meas_en && (state == ST_ARM) && rise;

    // A measurement only extends a run when it repeats the previous valid one.
    assign match_nxt = (prev_vld && (cnt == o_ratio)) ? match_sat_inc(match_cnt) : 4'd1;

    // Two-flop synchronizer, edge-detect delay flop and post-reset priming.
    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            d3     <= 1'b0;
            primed <= 2'b00;
        end else begin
            sync1  <= i_clk_in;
            sync2  <= sync1;
            d3     <= sync2;
            primed <= {primed[0], 1'b1};
        end
    end

    // Next-state logic; dropping the enable wins over everything else.
    always_comb begin
        state_nxt = state;
        if (!i_meas_en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_SYNC;
                end
                ST_SYNC: begin
                    // Only arm once the input is seen low, so an input that
                    // is already high cannot produce a false first edge.
                    if (primed[1] && !sync2) begin
                        state_nxt = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (rise) begin
                        state_nxt = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (tmo_evt) begin
                        state_nxt = ST_SYNC;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Period counter: restarts at 1 on every rise, saturates at CNT_MAX.
    always_comb begin
        cnt_nxt = cnt;
        if (!i_meas_en) begin
            cnt_nxt = CNT_ZERO;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_nxt = CNT_ZERO;
                end
                ST_SYNC: begin
                    cnt_nxt = CNT_ZERO;
                end
                ST_ARM: begin
                    if (rise) begin
                        cnt_nxt = CNT_ONE;
                    end
                end
                ST_COUNT: begin
                    if (rise) begin
                        cnt_nxt = CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        cnt_nxt = CNT_ZERO;
                    end else begin
                        cnt_nxt = cnt_sat_inc(cnt);
                    end
                end
                default: begin
                    cnt_nxt = CNT_ZERO;
                end
            endcase
        end
    end

    // State and period counter registers.
    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_IDLE;
            cnt   <= CNT_ZERO;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Stability tracker: any break in the measurement chain restarts the run.
    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            match_cnt <= 4'd0;
            prev_vld  <= 1'b0;
            o_stable  <= 1'b0;
        end else if (!i_meas_en || tmo_evt || arm_evt) begin
            match_cnt <= 4'd0;
            prev_vld  <= 1'b0;
            o_stable  <= 1'b0;
        end else if (meas_evt) begin
            match_cnt <= match_nxt;
            prev_vld  <= 1'b1;
            o_stable  <= (match_nxt >= STABLE_TGT);
        end
    end

    // Ratio output and the one-cycle valid/timeout pulses. A rise at
    // cnt==CNT_MAX is a measurement, so meas_evt is checked first.
    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_ratio     <= CNT_ZERO;
            o_ratio_vld <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_ratio_vld <= meas_evt;
            o_timeout   <= tmo_evt;
            if (meas_evt) begin
                o_ratio <= cnt;
            end else if (tmo_evt) begin
                o_ratio <= CNT_ZERO;
            end
        end
    end

endmodule

// File: tb/tb_clk_ratio_meas.sv
// Testbench for clk_ratio_meas: directed waveforms on i_clk_in with expected
// ratio/stable/timeout events queued up front and checked by a monitor.
module tb_clk_ratio_meas;

    logic       i_ref_clk = 1'b0;
    logic       i_rst;
    logic       i_meas_en;
    logic       i_clk_in;
    logic [7:0] o_ratio;
    logic       o_ratio_vld;
    logic       o_stable;
    logic       o_timeout;

    typedef struct {
        bit is_tmo;
        int ratio;
        bit stable;
        int gap;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_vld_cyc = 0;
    int   cur_test = 0;

    clk_ratio_meas #(
        .RATIO_WD   (8),
        .STABLE_CNT (4)
    ) dut (
        .i_ref_clk   (i_ref_clk),
        .i_rst       (i_rst),
        .i_meas_en   (i_meas_en),
        .i_clk_in    (i_clk_in),
        .o_ratio     (o_ratio),
        .o_ratio_vld (o_ratio_vld),
        .o_stable    (o_stable),
        .o_timeout   (o_timeout)
    );

    always #5 i_ref_clk = ~i_ref_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL test%0d %s: got %0d, expected %0d", cur_test, name, act, exp);
        end
    endtask

    task automatic push_m(input int r, input bit s);
        exp_t x;
        x.is_tmo = 1'b0;
        x.ratio  = r;
        x.stable = s;
        x.gap    = -1;
        sb.push_back(x);
    endtask

    task automatic push_t(input int gap);
        exp_t x;
        x.is_tmo = 1'b1;
        x.ratio  = 0;
        x.stable = 1'b0;
        x.gap    = gap;
        sb.push_back(x);
    endtask

    // Hold i_clk_in at v for n ref edges; always entered and left at posedge+1.
    task automatic hold(input bit v, input int n);
        i_clk_in = v;
        repeat (n) begin
            @(posedge i_ref_clk);
            #1;
        end
    endtask

    task automatic periods(input int n, input int h, input int l);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, h);
            hold(1'b0, l);
        end
    endtask

    task automatic drained(input string name);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic disable_meas();
        i_meas_en = 1'b0;
        hold(1'b0, 4);
    endtask

    task automatic enable_meas();
        i_meas_en = 1'b1;
        hold(1'b0, 4);
    endtask

    // Monitor: every valid or timeout pulse must match the head of the queue.
    always @(negedge i_ref_clk) begin
        cyc++;
        if (o_ratio_vld || o_timeout) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL test%0d unexpected_event: vld=%0b tmo=%0b ratio=%0d stable=%0b, expected no event",
                         cur_test, o_ratio_vld, o_timeout, o_ratio, o_stable);
            end else begin
                e = sb.pop_front();
                chk("event_is_timeout", int'(o_timeout), int'(e.is_tmo));
                chk("event_is_vld", int'(o_ratio_vld), int'(!e.is_tmo));
                chk("ratio", int'(o_ratio), e.ratio);
                chk("stable", int'(o_stable), int'(e.stable));
                if (e.gap >= 0) begin
                    chk("timeout_gap", cyc - last_vld_cyc, e.gap);
                end
            end
        end
        if (o_ratio_vld) begin
            last_vld_cyc = cyc;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        i_rst     = 1'b0;
        i_meas_en = 1'b0;
        i_clk_in  = 1'b0;
        repeat (3) @(posedge i_ref_clk);
        #1;
        chk("rst_ratio", int'(o_ratio), 0);
        chk("rst_vld", int'(o_ratio_vld), 0);
        chk("rst_stable", int'(o_stable), 0);
        chk("rst_timeout", int'(o_timeout), 0);
        i_rst = 1'b1;
        hold(1'b0, 2);

        // Even ratio: period 8, 4 high / 4 low
        cur_test = 1;
        enable_meas();
        push_m(8, 0); push_m(8, 0); push_m(8, 0);
        push_m(8, 1); push_m(8, 1); push_m(8, 1);
        periods(6, 4, 4);
        periods(1, 4, 4);
        drained("t1_drained");
        disable_meas();
        chk("t1_ratio_kept", int'(o_ratio), 8);
        chk("t1_stable_cleared", int'(o_stable), 0);

        // Odd ratio: period 5, 3/2 then 2/3 duty
        cur_test = 2;
        enable_meas();
        push_m(5, 0); push_m(5, 0); push_m(5, 0);
        for (int i = 0; i < 7; i++) push_m(5, 1);
        periods(5, 3, 2);
        periods(5, 2, 3);
        periods(1, 4, 4);
        drained("t2_drained");
        chk("t2_stable", int'(o_stable), 1);
        disable_meas();

        // Ratio change: 8 then 6
        cur_test = 3;
        enable_meas();
        push_m(8, 0); push_m(8, 0); push_m(8, 0);
        push_m(8, 1); push_m(8, 1); push_m(8, 1);
        push_m(6, 0); push_m(6, 0); push_m(6, 0);
        push_m(6, 1); push_m(6, 1);
        periods(6, 4, 4);
        periods(5, 3, 3);
        periods(1, 4, 4);
        drained("t3_drained");
        disable_meas();

        // Timeout after lock at 8, then relock
        cur_test = 4;
        enable_meas();
        push_m(8, 0); push_m(8, 0); push_m(8, 0);
        push_m(8, 1); push_m(8, 1);
        push_t(255);
        periods(5, 4, 4);
        hold(1'b1, 4);
        hold(1'b0, 300);
        drained("t4_drained_timeout");
        chk("t4_ratio_zero", int'(o_ratio), 0);
        chk("t4_stable_zero", int'(o_stable), 0);
        push_m(8, 0); push_m(8, 0); push_m(8, 0);
        push_m(8, 1); push_m(8, 1);
        periods(5, 4, 4);
        periods(1, 4, 4);
        drained("t4_drained_relock");
        disable_meas();

        // Boundaries: period 255 (no timeout) then period 2
        cur_test = 5;
        enable_meas();
        push_m(255, 0); push_m(255, 0);
        push_m(2, 0); push_m(2, 0); push_m(2, 0);
        push_m(2, 1); push_m(2, 1);
        periods(2, 100, 155);
        periods(5, 1, 1);
        periods(1, 4, 4);
        drained("t5_drained");
        disable_meas();

        // Enable dropped mid-period, then re-enabled
        cur_test = 6;
        enable_meas();
        push_m(8, 0); push_m(8, 0); push_m(8, 0); push_m(8, 1);
        periods(4, 4, 4);
        hold(1'b1, 4);
        hold(1'b0, 2);
        i_meas_en = 1'b0;
        hold(1'b0, 3);
        chk("t6_ratio_kept", int'(o_ratio), 8);
        chk("t6_stable_cleared", int'(o_stable), 0);
        drained("t6_drained_abort");
        enable_meas();
        push_m(8, 0); push_m(8, 0);
        periods(2, 4, 4);
        periods(1, 4, 4);
        drained("t6_drained_resume");

        // Reset released with the input held high
        cur_test = 7;
        i_clk_in = 1'b1;
        i_rst    = 1'b0;
        hold(1'b1, 2);
        chk("t7_rst_ratio", int'(o_ratio), 0);
        i_rst = 1'b1;
        hold(1'b1, 20);
        drained("t7_no_event_high");
        hold(1'b0, 4);
        push_m(8, 0); push_m(8, 0); push_m(8, 0);
        periods(3, 4, 4);
        periods(1, 4, 4);
        drained("t7_drained");
        disable_meas();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
